fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_cnt.sv | 27 ++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch controller
// Purpose: FSM state encoding, program entry addresses, done word and
//          prog_sel encoding used by fetch_ctrl and its bench.
// Ports:   none (package).
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [1:0] PSEL_PROD = 2'd0;
   localparam logic [1:0] PSEL_STR  = 2'd1;
   localparam logic [1:0] PSEL_PAIR = 2'd2;
   localparam logic [1:0] PSEL_RSVD = 2'd3;

   localparam logic [7:0] ENTRY_PROD = 8'd0;
   localparam logic [7:0] ENTRY_STR  = 8'd28;
   localparam logic [7:0] ENTRY_PAIR = 8'd48;

   localparam logic [8:0] DONE_WORD = 9'b0;

   function automatic logic [7:0] entry_of(input logic [1:0] sel);
      case (sel)
         PSEL_STR:  entry_of = ENTRY_STR;
         PSEL_PAIR: entry_of = ENTRY_PAIR;
         default:   entry_of = ENTRY_PROD;
      endcase
   endfunction

endpackage

// File: rtl/fetch_cnt.sv
// rtl/fetch_cnt.sv - saturating retired-instruction counter
// Purpose: counts retired instructions, sticks at all-ones, clears on clr.
// Ports:   clk, rst_n (async active-low), clr (synchronous clear, wins over
//          inc), inc (count enable), count [W-1:0].
module fetch_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - program fetch controller (PC sequencing, done/fault)
// Purpose: launches one of three programs, steps PC through instruction
//          memory, follows branches, stops on the done word or on an
//          illegal address.
// Config:  FETCH_CNT_EN defined -> retired counts retired instructions;
//          undefined -> retired tied to 0, no counter flops.
// Ports:   clk, rst_n (async active-low); start, prog_sel[1:0];
//          iptr[8:0] (instruction word at PC); stall; br_taken;
//          br_target[7:0]; PC[7:0]; instr_valid; busy; done; fault;
//          retired[CNT_W-1:0].
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [7:0] PC_LAST = 8'd68,
   parameter int         CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       prog_sel,
   input  logic [8:0]       iptr,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [7:0]       br_target,
   output logic [7:0]       PC,
   output logic             instr_valid,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   state_t state;
   logic   accept_start;
   logic   is_done_word;

   // start is only honoured outside RUN
   assign accept_start = start && (state != ST_RUN);
   assign is_done_word = (iptr == DONE_WORD);

   // busy is registered, so this is the only combinational output
   assign instr_valid  = busy && !stall && !is_done_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         PC    <= 8'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         fault <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (!stall) begin
                  // done word outranks any branch on the same instruction
                  if (is_done_word) begin
                     state <= ST_HALT;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (br_taken) begin
                     if (br_target > PC_LAST) begin
                        state <= ST_HALT;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                     end else begin
                        PC <= br_target;
                     end
                  end else if (PC == PC_LAST) begin
                     // running off the end faults instead of wrapping
                     state <= ST_HALT;
                     busy  <= 1'b0;
                     fault <= 1'b1;
                  end else begin
                     PC <= PC + 8'd1;
                  end
               end
            end
            default: begin
               if (accept_start) begin
                  done <= 1'b0;
                  if (prog_sel == PSEL_RSVD) begin
                     state <= ST_HALT;
                     busy  <= 1'b0;
                     fault <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     busy  <= 1'b1;
                     fault <= 1'b0;
                     PC    <= entry_of(prog_sel);
                  end
               end
            end
         endcase
      end
   end

`ifdef FETCH_CNT_EN
   fetch_cnt #(
      .W(CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept_start),
      .inc   (instr_valid),
      .count (retired)
   );
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

   localparam int LAST    = 68;
   localparam int RET_MAX = 65535;
`ifdef FETCH_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  prog_sel = 2'd0;
   logic [8:0]  iptr;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [7:0]  br_target = 8'd0;
   logic [7:0]  PC;
   logic        instr_valid;
   logic        busy;
   logic        done;
   logic        fault;
   logic [15:0] retired;

   logic [8:0]  mem [0:255];
   int          entry [0:2];

   // behavioural model of the program state
   bit m_run, m_done, m_fault;
   int m_pc, m_ret;

   int n_tests = 0;
   int n_fail  = 0;

   assign iptr = mem[PC];

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .prog_sel    (prog_sel),
      .iptr        (iptr),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .PC          (PC),
      .instr_valid (instr_valid),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .retired     (retired)
   );

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = 9'($urandom_range(1, 511));
   endtask

   task automatic drive(input bit st, input int sel, input bit sl, input bit bt, input int tg);
      start     = st;
      prog_sel  = 2'(sel);
      stall     = sl;
      br_taken  = bt;
      br_target = 8'(tg);
      #1;
   endtask

   task automatic model_reset();
      m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_ret = 0;
   endtask

   // one clock edge; the model applies the rules to the inputs held across it
   task automatic tick();
      @(posedge clk);
      #1;
      if (m_run) begin
         if (!stall) begin
            if (mem[m_pc] == 9'd0) begin
               m_run = 0; m_done = 1;
            end else begin
               if (CNT_ON && m_ret < RET_MAX) m_ret = m_ret + 1;
               if (br_taken) begin
                  if (int'(br_target) > LAST) begin m_run = 0; m_fault = 1; end
                  else m_pc = int'(br_target);
               end else if (m_pc == LAST) begin
                  m_run = 0; m_fault = 1;
               end else begin
                  m_pc = m_pc + 1;
               end
            end
         end
      end else if (start) begin
         m_done = 0; m_fault = 0; m_ret = 0;
         if (prog_sel == 2'd3) m_fault = 1;
         else begin m_pc = entry[prog_sel]; m_run = 1; end
      end
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (PC !== 8'd0) begin n_fail++; $display("FAIL reset_pc got %0d exp 0", PC); end
      n_tests++; if ({busy, done, fault, instr_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {busy, done, fault, instr_valid}); end
      n_tests++; if (retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired got %0d exp 0", retired); end
      // first edge after release must accept start
      drive(1, 2, 0, 0, 0);
      tick();
      n_tests++; if (PC !== 8'd48 || busy !== 1'b1) begin n_fail++; $display("FAIL first_start got pc=%0d busy=%b exp pc=48 busy=1", PC, busy); end
   endtask

   task automatic test_string_match();
      int cyc;
      do_reset();
      fill_mem();
      mem[47] = 9'd0;
      drive(1, 1, 0, 0, 0);
      tick();
      drive(0, 1, 0, 0, 0);
      cyc = 0;
      while (!done && cyc < 100) begin
         n_tests++; if (PC !== 8'(m_pc)) begin n_fail++; $display("FAIL str_step got %0d exp %0d", PC, m_pc); end
         tick();
         cyc++;
      end
      n_tests++; if (cyc >= 100) begin n_fail++; $display("FAIL str_timeout got done=%b exp 1", done); end
      n_tests++; if (PC !== 8'd47 || done !== 1'b1 || fault !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL str_end got pc=%0d d=%b f=%b b=%b exp pc=47 d=1 f=0 b=0", PC, done, fault, busy); end
      n_tests++; if (retired !== 16'(CNT_ON ? 19 : 0)) begin n_fail++; $display("FAIL str_retired got %0d exp %0d", retired, CNT_ON ? 19 : 0); end
   endtask

   task automatic test_stall_branch();
      do_reset();
      fill_mem();
      drive(1, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) tick();
      n_tests++; if (PC !== 8'd40) begin n_fail++; $display("FAIL sb_reach got %0d exp 40", PC); end
      drive(0, 0, 1, 1, 32);
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL sb_ivalid got %b exp 0", instr_valid); end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++; if (PC !== 8'd40 || busy !== 1'b1) begin n_fail++; $display("FAIL sb_hold got pc=%0d busy=%b exp 40 1", PC, busy); end
      end
      drive(0, 0, 0, 1, 32);
      tick();
      n_tests++; if (PC !== 8'd32) begin n_fail++; $display("FAIL sb_branch got %0d exp 32", PC); end
      n_tests++; if (retired !== 16'(m_ret)) begin n_fail++; $display("FAIL sb_retired got %0d exp %0d", retired, m_ret); end
   endtask

   task automatic test_bad_target();
      do_reset();
      fill_mem();
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      drive(0, 0, 0, 1, 200);
      tick();
      n_tests++; if (fault !== 1'b1 || done !== 1'b0 || PC !== 8'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL badtgt got f=%b d=%b pc=%0d b=%b exp 1 0 5 0", fault, done, PC, busy); end
      drive(1, 2, 0, 0, 0);
      tick();
      n_tests++; if (fault !== 1'b0 || PC !== 8'd48 || busy !== 1'b1) begin n_fail++; $display("FAIL restart got f=%b pc=%0d b=%b exp 0 48 1", fault, PC, busy); end
   endtask

   task automatic test_reserved();
      do_reset();
      drive(1, 3, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (fault !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rsvd got f=%b b=%b d=%b exp 1 0 0", fault, busy, done); end
         tick();
      end
   endtask

   task automatic test_pc_last();
      do_reset();
      fill_mem();
      drive(1, 2, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      n_tests++; if (PC !== 8'd68 || busy !== 1'b1) begin n_fail++; $display("FAIL last_reach got pc=%0d b=%b exp 68 1", PC, busy); end
      tick();
      n_tests++; if (PC !== 8'd68 || fault !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL last_fault got pc=%0d f=%b b=%b exp 68 1 0", PC, fault, busy); end
   endtask

   task automatic test_done_priority();
      do_reset();
      fill_mem();
      mem[30] = 9'd0;
      drive(1, 1, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0);
      tick();
      tick();
      n_tests++; if (PC !== 8'd30 || busy !== 1'b1) begin n_fail++; $display("FAIL start_in_run got pc=%0d b=%b exp 30 1", PC, busy); end
      drive(0, 0, 0, 1, 10);
      tick();
      n_tests++; if (done !== 1'b1 || fault !== 1'b0 || PC !== 8'd30) begin n_fail++; $display("FAIL done_prio got d=%b f=%b pc=%0d exp 1 0 30", done, fault, PC); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      fill_mem();
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 13; i++) tick();
      n_tests++; if (PC !== 8'd13) begin n_fail++; $display("FAIL mid_reach got %0d exp 13", PC); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (PC !== 8'd0 || {busy, done, fault, instr_valid} !== 4'b0 || retired !== 16'd0) begin n_fail++; $display("FAIL mid_reset got pc=%0d flags=%b ret=%0d exp 0 0000 0", PC, {busy, done, fault, instr_valid}, retired); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      n_tests++; if (PC !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle got pc=%0d b=%b exp 0 0", PC, busy); end
   endtask

   task automatic test_product_run();
      int cyc;
      do_reset();
      fill_mem();
      mem[27] = 9'd0;
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      cyc = 0;
      while (!done && cyc < 100) begin
         n_tests++; if (retired !== 16'(m_ret)) begin n_fail++; $display("FAIL prod_ret got %0d exp %0d", retired, m_ret); end
         tick();
         cyc++;
      end
      n_tests++; if (done !== 1'b1 || PC !== 8'd27) begin n_fail++; $display("FAIL prod_end got d=%b pc=%0d exp 1 27", done, PC); end
      n_tests++; if (retired !== 16'(CNT_ON ? 27 : 0)) begin n_fail++; $display("FAIL prod_retired got %0d exp %0d", retired, CNT_ON ? 27 : 0); end
   endtask

   task automatic test_random();
      bit st, sl, bt;
      int sel, tg;
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 24) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      for (int c = 0; c < 3000; c++) begin
         st  = ($urandom_range(0, 7) == 0);
         sel = $urandom_range(0, 3);
         sl  = ($urandom_range(0, 3) == 0);
         bt  = ($urandom_range(0, 5) == 0);
         tg  = ($urandom_range(0, 9) == 0) ? $urandom_range(69, 255) : $urandom_range(0, LAST);
         drive(st, sel, sl, bt, tg);
         n_tests++; if (PC !== 8'(m_pc)) begin n_fail++; $display("FAIL rnd_pc c=%0d got %0d exp %0d", c, PC, m_pc); end
         n_tests++; if (busy !== m_run || done !== m_done || fault !== m_fault) begin n_fail++; $display("FAIL rnd_flags c=%0d got b=%b d=%b f=%b exp %b %b %b", c, busy, done, fault, m_run, m_done, m_fault); end
         n_tests++; if (instr_valid !== (m_run && !sl && mem[m_pc] != 9'd0)) begin n_fail++; $display("FAIL rnd_ivalid c=%0d got %b", c, instr_valid); end
         n_tests++; if (retired !== 16'(m_ret)) begin n_fail++; $display("FAIL rnd_ret c=%0d got %0d exp %0d", c, retired, m_ret); end
         n_tests++; if (done === 1'b1 && fault === 1'b1) begin n_fail++; $display("FAIL rnd_excl c=%0d got done=1 fault=1 exp not both", c); end
         tick();
      end
   endtask

   initial begin
      entry[0] = 0; entry[1] = 28; entry[2] = 48;
      fill_mem();
      model_reset();
      test_reset();
      test_string_match();
      test_stall_branch();
      test_bad_target();
      test_reserved();
      test_pc_last();
      test_done_priority();
      test_reset_mid_run();
      test_product_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
